// File: rtl/tb_mem_regbus_multi_if.sv
// -----------------------------------------------------------------------------
// tb_mem_regbus_multi_if
// Bundles the per-port regbus request/response vectors of tb_mem_regbus_multi.
// Signal names are given from the memory's point of view (_i = into the memory,
// _o = out of the memory). Port p occupies slice p of every vector.
//   req_valid_i  [NumPorts]              request valid
//   req_write_i  [NumPorts]              1 = write, 0 = read
//   req_addr_i   [NumPorts*AddrWidth]    byte address
//   req_wdata_i  [NumPorts*DataWidth]    write data
//   req_wstrb_i  [NumPorts*DataWidth/8]  byte strobes
//   rsp_ready_o  [NumPorts]              one-cycle completion pulse
//   rsp_rdata_o  [NumPorts*DataWidth]    read data (valid with ready)
//   rsp_error_o  [NumPorts]              error flag (valid with ready)
// Modports: master (request side), slave (memory side).
// -----------------------------------------------------------------------------
interface tb_mem_regbus_multi_if #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 32
);
  logic [NumPorts-1:0]             req_valid_i;
  logic [NumPorts-1:0]             req_write_i;
  logic [NumPorts*AddrWidth-1:0]   req_addr_i;
  logic [NumPorts*DataWidth-1:0]   req_wdata_i;
  logic [NumPorts*DataWidth/8-1:0] req_wstrb_i;
  logic [NumPorts-1:0]             rsp_ready_o;
  logic [NumPorts*DataWidth-1:0]   rsp_rdata_o;
  logic [NumPorts-1:0]             rsp_error_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  rsp_ready_o, rsp_rdata_o, rsp_error_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output rsp_ready_o, rsp_rdata_o, rsp_error_o
  );
endinterface

// File: rtl/tb_mem_regbus_multi.sv
// -----------------------------------------------------------------------------
// tb_mem_regbus_multi
// Multi-port register-bus test memory. NumPorts request ports share one
// word-addressed array through a round-robin arbiter; each access takes
// 2+Latency cycles (IDLE -> WAIT x Latency -> RESP). Supports byte strobes and
// optional error responses for addresses outside the mapped window.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (clears FSM, arbiter and memory)
//   bus    tb_mem_regbus_multi_if.slave, all request/response vectors
// -----------------------------------------------------------------------------
module tb_mem_regbus_multi #(
  parameter int unsigned          NumPorts        = 2,
  parameter int unsigned          AddrWidth       = 48,
  parameter int unsigned          DataWidth       = 32,
  parameter int unsigned          NumWords        = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr        = '0,
  parameter int unsigned          Latency         = 2,
  parameter bit                   ErrOnOutOfRange = 1'b1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  tb_mem_regbus_multi_if.slave bus
);

  localparam int unsigned ByteW = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(ByteW);
  localparam int unsigned IdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned PtrW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned CntW  = (Latency > 0) ? $clog2(Latency + 1) : 1;
  // Size of the mapped window in bytes, one bit wider than an address.
  localparam logic [AddrWidth:0] SpanBytes = (AddrWidth + 1)'(NumWords * ByteW);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e                state_q;
  logic [PtrW-1:0]       rr_ptr_q;
  logic [PtrW-1:0]       grant_q;
  logic [CntW-1:0]       cnt_q;
  logic [DataWidth-1:0]  mem_q [NumWords];

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first requesting port at or after rr_ptr_q.
  // ---------------------------------------------------------------------------
  logic            arb_found;
  logic [PtrW-1:0] arb_idx;

  always_comb begin
    int unsigned cand;
    logic [PtrW-1:0] cand_idx;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NumPorts; i++) begin
      cand = 32'(rr_ptr_q) + 32'(i);
      if (cand >= NumPorts) begin
        cand = cand - NumPorts;
      end
      cand_idx = PtrW'(cand);
      if (!arb_found && bus.req_valid_i[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted-port request fields and address decode.
  // ---------------------------------------------------------------------------
  logic                 g_valid;
  logic                 g_write;
  logic [AddrWidth-1:0] g_addr;
  logic [DataWidth-1:0] g_wdata;
  logic [ByteW-1:0]     g_wstrb;
  logic [AddrWidth:0]   offset_ext;
  logic                 in_range;
  logic [IdxW-1:0]      idx;
  logic [DataWidth-1:0] cur_word;
  logic [DataWidth-1:0] wr_word;

  assign g_valid = bus.req_valid_i[grant_q];
  assign g_write = bus.req_write_i[grant_q];
  assign g_addr  = bus.req_addr_i[grant_q*AddrWidth +: AddrWidth];
  assign g_wdata = bus.req_wdata_i[grant_q*DataWidth +: DataWidth];
  assign g_wstrb = bus.req_wstrb_i[grant_q*ByteW +: ByteW];

  // The extra top bit is the borrow: set when the address lies below BaseAddr.
  assign offset_ext = {1'b0, g_addr} - {1'b0, BaseAddr};
  assign in_range   = !offset_ext[AddrWidth] && (offset_ext < SpanBytes);
  // Taking only IdxW bits of the word index gives the modulo-NumWords wrap.
  assign idx        = offset_ext[OffW +: IdxW];
  assign cur_word   = mem_q[idx];

  // Byte-strobe merge of write data into the current word.
  for (genvar gi = 0; gi < ByteW; gi++) begin : g_wbyte
    assign wr_word[gi*8 +: 8] = g_wstrb[gi] ? g_wdata[gi*8 +: 8] : cur_word[gi*8 +: 8];
  end

  // A response fires only while the granted master still holds valid.
  logic                 resp_fire;
  logic                 rsp_err;
  logic                 do_write;
  logic [DataWidth-1:0] rsp_data;

  assign resp_fire = (state_q == RESP) && g_valid;
  assign rsp_err   = ErrOnOutOfRange && !in_range;
  assign do_write  = resp_fire && g_write && !rsp_err;
  assign rsp_data  = (resp_fire && !g_write && !rsp_err) ? cur_word : '0;

  // ---------------------------------------------------------------------------
  // Response fan-out: only the granted port sees ready/data/error.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_rsp
    logic sel;
    assign sel = resp_fire && (grant_q == PtrW'(gi));
    assign bus.rsp_ready_o[gi]                          = sel;
    assign bus.rsp_rdata_o[gi*DataWidth +: DataWidth]   = sel ? rsp_data : '0;
    assign bus.rsp_error_o[gi]                          = sel && rsp_err;
  end

  // ---------------------------------------------------------------------------
  // Control FSM, arbiter pointer and memory array.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      for (int w = 0; w < NumWords; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      if (state_q != IDLE) begin
        assert (g_valid)
          else $warning("regbus protocol violation: granted port %0d dropped valid before ready",
                        grant_q);
      end
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q <= arb_idx;
            if (Latency == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CntW'(Latency - 1);
            end
          end
        end
        WAIT: begin
          // Abandoned request: drop it silently, pointer untouched.
          if (!g_valid) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          if (g_valid) begin
            rr_ptr_q <= (grant_q == PtrW'(NumPorts - 1)) ? '0 : grant_q + 1'b1;
          end
          if (do_write) begin
            mem_q[idx] <= wr_word;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_mem_regbus_multi.sv
// -----------------------------------------------------------------------------
// tb_tb_mem_regbus_multi
// Directed bench for tb_mem_regbus_multi. Instance A uses the default build
// (Latency=2, errors on out-of-range); instance B uses Latency=0 with address
// wrap. Expected responses are queued when a request is driven and compared
// when a ready pulse appears.
// -----------------------------------------------------------------------------
module tb_tb_mem_regbus_multi;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  tb_mem_regbus_multi_if #(.NumPorts(2), .AddrWidth(48), .DataWidth(32)) ifa ();
  tb_mem_regbus_multi_if #(.NumPorts(2), .AddrWidth(48), .DataWidth(32)) ifb ();

  tb_mem_regbus_multi #(
    .NumPorts(2), .AddrWidth(48), .DataWidth(32), .NumWords(1024),
    .BaseAddr(48'h0), .Latency(2), .ErrOnOutOfRange(1'b1)
  ) dut_a (
    .clk_i(clk),
    .rst_i(rst_a),
    .bus  (ifa)
  );

  tb_mem_regbus_multi #(
    .NumPorts(2), .AddrWidth(48), .DataWidth(32), .NumWords(1024),
    .BaseAddr(48'h0), .Latency(0), .ErrOnOutOfRange(1'b0)
  ) dut_b (
    .clk_i(clk),
    .rst_i(rst_b),
    .bus  (ifb)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  task automatic push_exp(input int port, input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    e.err   = err;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  task automatic drive(input bit sel_b, input int port, input logic v, input logic wr,
                       input logic [47:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    if (sel_b) begin
      ifb.req_valid_i[port]          = v;
      ifb.req_write_i[port]          = wr;
      ifb.req_addr_i[port*48 +: 48]  = addr;
      ifb.req_wdata_i[port*32 +: 32] = wd;
      ifb.req_wstrb_i[port*4 +: 4]   = ws;
    end else begin
      ifa.req_valid_i[port]          = v;
      ifa.req_write_i[port]          = wr;
      ifa.req_addr_i[port*48 +: 48]  = addr;
      ifa.req_wdata_i[port*32 +: 32] = wd;
      ifa.req_wstrb_i[port*4 +: 4]   = ws;
    end
  endtask

  task automatic sample(input bit sel_b, output logic [1:0] rdy, output logic [63:0] rd,
                        output logic [1:0] er);
    if (sel_b) begin
      rdy = ifb.rsp_ready_o;
      rd  = ifb.rsp_rdata_o;
      er  = ifb.rsp_error_o;
    end else begin
      rdy = ifa.rsp_ready_o;
      rd  = ifa.rsp_rdata_o;
      er  = ifa.rsp_error_o;
    end
  endtask

  // Waits (bounded) for the next ready pulse and checks it against the
  // oldest queued expectation; lat counts negedges since the call.
  task automatic wait_rsp(input bit sel_b, input string tag);
    exp_t        e;
    int          n;
    int          other;
    bit          seen;
    logic [1:0]  rdy;
    logic [63:0] rd;
    logic [1:0]  er;
    logic [1:0]  one_hot;
    e       = sb.pop_front();
    other   = 1 - e.port;
    one_hot = 2'b01;
    seen    = 1'b0;
    n       = 0;
    rdy     = '0;
    rd      = '0;
    er      = '0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      sample(sel_b, rdy, rd, er);
      if (rdy != 2'b00) seen = 1'b1;
    end
    chk({tag, "_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      chk({tag, "_ready"}, 64'(rdy), 64'(one_hot << e.port));
      chk({tag, "_lat"}, 64'(n), 64'(e.lat));
      chk({tag, "_rdata"}, 64'(rd[e.port*32 +: 32]), 64'(e.rdata));
      chk({tag, "_err"}, 64'(er[e.port]), 64'(e.err));
      chk({tag, "_idle_port"}, {31'b0, er[other], rd[other*32 +: 32]}, 64'(0));
    end
    $display("txn %s: port=%0d rdata=%08h err=%0d after %0d cycles", tag, e.port,
             rd[e.port*32 +: 32], er[e.port], n);
  endtask

  // Single transaction issued at a negedge in which the FSM is idle; valid is
  // held through the completion edge and dropped at the following negedge.
  task automatic do_req(input bit sel_b, input int port, input logic wr, input logic [47:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    drive(sel_b, port, 1'b1, wr, addr, wd, ws);
    push_exp(port, exp_rdata, exp_err, sel_b ? 1 : 3);
    wait_rsp(sel_b, tag);
    @(negedge clk);
    drive(sel_b, port, 1'b0, 1'b0, 48'h0, 32'h0, 4'h0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.req_valid_i = '0; ifa.req_write_i = '0; ifa.req_addr_i = '0;
    ifa.req_wdata_i = '0; ifa.req_wstrb_i = '0;
    ifb.req_valid_i = '0; ifb.req_write_i = '0; ifb.req_addr_i = '0;
    ifb.req_wdata_i = '0; ifb.req_wstrb_i = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_a_ready", 64'(ifa.rsp_ready_o), 64'(0));
    chk("rst_a_rdata", ifa.rsp_rdata_o, 64'(0));
    chk("rst_a_error", 64'(ifa.rsp_error_o), 64'(0));
    chk("rst_b_ready", 64'(ifb.rsp_ready_o), 64'(0));
    chk("rst_b_rdata", ifb.rsp_rdata_o, 64'(0));
    chk("rst_b_error", 64'(ifb.rsp_error_o), 64'(0));
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Basic read / writes with strobes on instance A.
    do_req(0, 0, 1'b0, 48'h10, 32'h0, 4'h0, 32'h0, 1'b0, "a_rd10");
    do_req(0, 0, 1'b1, 48'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "a_wr40_full");
    do_req(0, 0, 1'b1, 48'h40, 32'h000000AA, 4'h1, 32'h0, 1'b0, "a_wr40_byte0");
    do_req(0, 0, 1'b0, 48'h40, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "a_rd40");
    do_req(0, 0, 1'b1, 48'h40, 32'hCAFEF00D, 4'h0, 32'h0, 1'b0, "a_wr40_nostrb");
    do_req(0, 0, 1'b0, 48'h42, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, "a_rd42_unaligned");
    do_req(0, 0, 1'b1, 48'h0, 32'h11112222, 4'hF, 32'h0, 1'b0, "a_wr00");
    do_req(0, 0, 1'b1, 48'h4, 32'h33334444, 4'hF, 32'h0, 1'b0, "a_wr04");

    // Out of range: error, no write, no aliasing onto word 0.
    do_req(0, 0, 1'b0, 48'h1000, 32'h0, 4'h0, 32'h0, 1'b1, "a_rd_oor");
    do_req(0, 0, 1'b1, 48'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "a_wr_oor");
    do_req(0, 0, 1'b0, 48'h0, 32'h0, 4'h0, 32'h11112222, 1'b0, "a_rd00_after_oor");

    // Port 1 access; pointer moves back to port 0.
    do_req(0, 1, 1'b0, 48'h4, 32'h0, 4'h0, 32'h33334444, 1'b0, "a_p1_rd04");

    // Both ports requesting continuously: grants alternate 0,1,0,1 every 4 cycles.
    drive(0, 0, 1'b1, 1'b0, 48'h0, 32'h0, 4'h0);
    drive(0, 1, 1'b1, 1'b0, 48'h4, 32'h0, 4'h0);
    push_exp(0, 32'h11112222, 1'b0, 3);
    push_exp(1, 32'h33334444, 1'b0, 4);
    push_exp(0, 32'h11112222, 1'b0, 4);
    push_exp(1, 32'h33334444, 1'b0, 4);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(0, "a_rr");
    end
    @(negedge clk);
    drive(0, 0, 1'b0, 1'b0, 48'h0, 32'h0, 4'h0);
    drive(0, 1, 1'b0, 1'b0, 48'h0, 32'h0, 4'h0);

    // Port 1 abandons its request in WAIT: no ready, FSM idle next cycle.
    drive(0, 1, 1'b1, 1'b0, 48'h4, 32'h0, 4'h0);
    @(negedge clk);
    chk("a_viol_wait_ready", 64'(ifa.rsp_ready_o), 64'(0));
    drive(0, 1, 1'b0, 1'b0, 48'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("a_viol_idle_ready", 64'(ifa.rsp_ready_o), 64'(0));
    do_req(0, 0, 1'b0, 48'h0, 32'h0, 4'h0, 32'h11112222, 1'b0, "a_after_viol_p0");

    // Reset in WAIT during a write: aborted, memory cleared.
    drive(0, 0, 1'b1, 1'b1, 48'h80, 32'h12345678, 4'hF);
    @(negedge clk);
    rst_a = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 48'h0, 32'h0, 4'h0);
    #1;
    chk("a_midrst_ready", 64'(ifa.rsp_ready_o), 64'(0));
    @(negedge clk);
    chk("a_midrst_ready_hold", 64'(ifa.rsp_ready_o), 64'(0));
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    do_req(0, 0, 1'b0, 48'h80, 32'h0, 4'h0, 32'h0, 1'b0, "a_rd80_after_rst");
    do_req(0, 0, 1'b0, 48'h40, 32'h0, 4'h0, 32'h0, 1'b0, "a_rd40_cleared");

    // Instance B: zero latency, out-of-range addresses wrap.
    do_req(1, 0, 1'b1, 48'h0, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, "b_wr00");
    do_req(1, 0, 1'b0, 48'h1000, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, "b_rd_wrap0");
    do_req(1, 0, 1'b0, 48'h1004, 32'h0, 4'h0, 32'h0, 1'b0, "b_rd_wrap1");
    do_req(1, 1, 1'b1, 48'h1008, 32'h00000077, 4'hF, 32'h0, 1'b0, "b_wr_wrap2");
    do_req(1, 1, 1'b0, 48'h8, 32'h0, 4'h0, 32'h00000077, 1'b0, "b_rd08");
    do_req(1, 1, 1'b0, 48'h0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, "b_p1_rd00");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tb_mem_regbus_multi.md
Name: tb_mem_regbus_multi

Overview:
- Parametrised multi-port register-bus test memory for the Occamy test harness.
- Successor to the single-port, zero-wait regbus memory model. Adds N request ports with round-robin arbitration, programmable response latency, byte strobes and out-of-range error responses.
- Serves peripheral-side regbus channels (bootrom, clk_mgr, chip_ctrl, ...) from one shared word-addressed array.

Parameters:
- NumPorts, 2, number of independent regbus request ports (>=1)
- AddrWidth, 48, regbus address width
- DataWidth, 32, data width in bits (power of two, >=8)
- NumWords, 1024, memory depth in DataWidth words (power of two)
- BaseAddr, 0, byte address of word 0
- Latency, 2, extra wait cycles between grant and response (>=0)
- ErrOnOutOfRange, 1, 1 = out-of-range access returns error; 0 = address wraps modulo NumWords

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  NumPorts  request valid per port
- req_write_i  in  NumPorts  1 = write, 0 = read
- req_addr_i  in  NumPorts*AddrWidth  byte address; port p at [p*AddrWidth +: AddrWidth]
- req_wdata_i  in  NumPorts*DataWidth  write data
- req_wstrb_i  in  NumPorts*DataWidth/8  byte strobes
- rsp_ready_o  out  NumPorts  one-cycle completion pulse per port
- rsp_rdata_o  out  NumPorts*DataWidth  read data, valid only while that port's ready is high
- rsp_error_o  out  NumPorts  error flag, valid only while that port's ready is high

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, rr_ptr=0, grant=0, cnt=0.
  - All memory words cleared to 0.
  - rsp_ready_o=0, rsp_rdata_o=0, rsp_error_o=0.
  - Reset mid-transaction aborts it with no write and no response.
- Handshake:
  - Master raises valid and holds write/addr/wdata/wstrb stable until it sees ready=1.
  - Transaction completes in the ready cycle.
  - Valid may drop only after ready.
- Address decode:
  - offset = addr - BaseAddr; word index = offset >> log2(DataWidth/8).
  - Low offset bits are ignored (no misalignment error).
  - In range when BaseAddr <= addr < BaseAddr + NumWords*DataWidth/8.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if any valid, grant the first requesting port at or after rr_ptr (cyclic search) and latch its index. Go to RESP if Latency==0, else to WAIT with cnt=Latency-1.
  - WAIT: cnt==0 -> RESP; else cnt-1.
  - RESP: assert rsp_ready_o[grant] only; set rr_ptr=(grant+1) mod NumPorts; go to IDLE.
- Response latency:
  - Valid sampled in IDLE at cycle t -> ready at cycle t+1+Latency.
  - Back-to-back throughput is one access per 2+Latency cycles.
- Access in RESP:
  - Read: rdata = mem[idx], error=0.
  - Write: at the RESP clock edge, bytes with wstrb=1 are updated, others kept; rdata=0, error=0.
  - wstrb=0 write: completes normally, memory unchanged.
  - Out of range with ErrOnOutOfRange=1: error=1, rdata=0, no write.
  - Out of range with ErrOnOutOfRange=0: idx = offset word index mod NumWords.
- Non-granted ports: ready=0, rdata=0, error=0.
- Granted port drops valid during WAIT or RESP (protocol violation):
  - FSM returns to IDLE with no write and no ready.
  - rr_ptr is unchanged.
  - A simulation assertion fires.
- Simultaneous requests: exactly one grant per transaction; rr_ptr rotation guarantees each requester is served within NumPorts transactions.
- Arithmetic: rr_ptr wraps from NumPorts-1 to 0; cnt width is clog2(Latency+1), minimum 1.

Test Plan:
- Reset then port0 read at addr BaseAddr+0x10, Latency=2 -> ready on cycle t+3, rdata=0x0, error=0.
- Port0 writes 0xDEADBEEF (wstrb=0xF) to 0x40, then writes 0x000000AA with wstrb=0x1 to 0x40, then reads 0x40 -> rdata=0xDEADBEAA.
- Ports 0 and 1 both valid continuously, reading 0x0 and 0x4 -> grants alternate 0,1,0,1; each port sees ready every 2*(2+Latency)=8 cycles.
- Read at BaseAddr+NumWords*4 with ErrOnOutOfRange=1 -> error=1, rdata=0. A write to the same address leaves mem[0] unchanged. With ErrOnOutOfRange=0, the same read returns mem[0].
- Latency=0 build: valid sampled in IDLE at cycle t -> ready at t+1. Reset asserted in WAIT during a write of 0x12345678 -> no ready; a subsequent read of that address returns 0.
- Port1 drops valid during WAIT -> no ready on port1, assertion fires, FSM is in IDLE next cycle, and a port0 request is then granted normally.
